// File: rtl/bram_o_arbiter_pkg.sv
// bram_o_arbiter_pkg: shared owner encoding and default BRAM address widths
package bram_o_arbiter_pkg;
  typedef enum logic {OWNER_ENG = 1'b0, OWNER_HOST = 1'b1} owner_e;
  localparam int LINE_W_DEF = 6;
  localparam int COL_W_DEF = 3;
endpackage

// File: rtl/bram_o_arbiter_tag_fifo.sv
// tag_fifo: owner-tag FIFO; a pop in the same cycle frees room for a push at full
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/bram_o_arbiter.sv
// bram_o_arbiter: engine/host arbiter for the BRAM O-port with in-order read-data routing
module bram_o_arbiter
  import bram_o_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int TAG_DEPTH = 4
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_ATTN_BUSY,
  input  logic              I_ENG_REQ,
  input  logic              I_ENG_WE,
  input  logic [LINE_W-1:0] I_ENG_LINE,
  input  logic [COL_W-1:0]  I_ENG_COL,
  output logic              O_ENG_GNT,
  output logic              O_ENG_RD_VLD,
  input  logic              I_HOST_REQ,
  input  logic [LINE_W-1:0] I_HOST_LINE,
  input  logic [COL_W-1:0]  I_HOST_COL,
  output logic              O_HOST_GNT,
  output logic              O_HOST_RD_VLD,
  output logic              O_BRAM_ENA,
  output logic              O_BRAM_WEA,
  output logic [LINE_W-1:0] O_BRAM_LINE,
  output logic [COL_W-1:0]  O_BRAM_COL,
  input  logic              I_BRAM_RD_VLD,
  output logic              O_ERR
);
  owner_e last_q, last_d, tag_dout, tag_din;
  logic ena_q, ena_d, wea_q, wea_d, err_q, err_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [COL_W-1:0] col_q, col_d;
  logic tag_full, tag_empty, tag_push, pop, can_read, eng_ok, host_ok, eng_gnt, host_gnt;
  logic [$clog2(TAG_DEPTH):0] tag_cnt;
  tag_fifo #(.DEPTH(TAG_DEPTH), .W(1)) u_tag_fifo (
    .clk_i(I_CLK),
    .rst_i(I_RST),
    .push_i(tag_push),
    .pop_i(pop),
    .din_i(tag_din),
    .dout_o(tag_dout),
    .full_o(tag_full),
    .empty_o(tag_empty),
    .count_o(tag_cnt)
  );
  // A same-cycle pop makes room, so a read may be granted even when the FIFO is full.
  always_comb begin
    pop = I_BRAM_RD_VLD & ~tag_empty;
    can_read = ~tag_full | pop;
    eng_ok = ~I_RST & I_ENG_REQ & (I_ENG_WE | can_read);
    host_ok = ~I_RST & I_HOST_REQ & can_read;
    eng_gnt = I_ATTN_BUSY ? eng_ok : eng_ok & (~host_ok | last_q == OWNER_HOST);
    host_gnt = I_ATTN_BUSY ? host_ok & ~I_ENG_REQ : host_ok & (~eng_ok | last_q == OWNER_ENG);
    tag_push = (eng_gnt & ~I_ENG_WE) | host_gnt;
    tag_din = host_gnt ? OWNER_HOST : OWNER_ENG;
    last_d = eng_gnt ? OWNER_ENG : host_gnt ? OWNER_HOST : last_q;
    ena_d = eng_gnt | host_gnt;
    wea_d = eng_gnt & I_ENG_WE;
    line_d = eng_gnt ? I_ENG_LINE : host_gnt ? I_HOST_LINE : '0;
    col_d = eng_gnt ? I_ENG_COL : host_gnt ? I_HOST_COL : '0;
    err_d = err_q | (I_BRAM_RD_VLD & tag_cnt == '0);
  end
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      last_q <= OWNER_HOST;
      ena_q <= 1'b0;
      wea_q <= 1'b0;
      line_q <= '0;
      col_q <= '0;
      err_q <= 1'b0;
    end else begin
      last_q <= last_d;
      ena_q <= ena_d;
      wea_q <= wea_d;
      line_q <= line_d;
      col_q <= col_d;
      err_q <= err_d;
    end
  end
  assign O_ENG_GNT = eng_gnt;
  assign O_HOST_GNT = host_gnt;
  assign O_ENG_RD_VLD = pop & tag_dout == OWNER_ENG;
  assign O_HOST_RD_VLD = pop & tag_dout == OWNER_HOST;
  assign O_BRAM_ENA = ena_q;
  assign O_BRAM_WEA = wea_q;
  assign O_BRAM_LINE = line_q;
  assign O_BRAM_COL = col_q;
  assign O_ERR = err_q;
endmodule

// File: tb/tb_bram_o_arbiter.sv
// tb_bram_o_arbiter: directed self-checking bench for bram_o_arbiter
module tb_bram_o_arbiter;
  logic I_CLK, I_RST, I_ATTN_BUSY, I_ENG_REQ, I_ENG_WE, I_HOST_REQ, I_BRAM_RD_VLD;
  logic [5:0] I_ENG_LINE, I_HOST_LINE, O_BRAM_LINE;
  logic [2:0] I_ENG_COL, I_HOST_COL, O_BRAM_COL;
  logic O_ENG_GNT, O_ENG_RD_VLD, O_HOST_GNT, O_HOST_RD_VLD, O_BRAM_ENA, O_BRAM_WEA, O_ERR;
  int checks = 0;
  int errors = 0;
  bram_o_arbiter dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_ATTN_BUSY(I_ATTN_BUSY),
    .I_ENG_REQ(I_ENG_REQ), .I_ENG_WE(I_ENG_WE), .I_ENG_LINE(I_ENG_LINE), .I_ENG_COL(I_ENG_COL),
    .O_ENG_GNT(O_ENG_GNT), .O_ENG_RD_VLD(O_ENG_RD_VLD),
    .I_HOST_REQ(I_HOST_REQ), .I_HOST_LINE(I_HOST_LINE), .I_HOST_COL(I_HOST_COL),
    .O_HOST_GNT(O_HOST_GNT), .O_HOST_RD_VLD(O_HOST_RD_VLD),
    .O_BRAM_ENA(O_BRAM_ENA), .O_BRAM_WEA(O_BRAM_WEA), .O_BRAM_LINE(O_BRAM_LINE), .O_BRAM_COL(O_BRAM_COL),
    .I_BRAM_RD_VLD(I_BRAM_RD_VLD), .O_ERR(O_ERR)
  );
  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge I_CLK);
    #1;
  endtask
  task automatic idle_in();
    I_ATTN_BUSY = 0; I_ENG_REQ = 0; I_ENG_WE = 0; I_HOST_REQ = 0; I_BRAM_RD_VLD = 0;
    I_ENG_LINE = 0; I_ENG_COL = 0; I_HOST_LINE = 0; I_HOST_COL = 0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_eng_gnt"}, O_ENG_GNT, 0);
    chk({tag, "_host_gnt"}, O_HOST_GNT, 0);
    chk({tag, "_ena"}, O_BRAM_ENA, 0);
    chk({tag, "_wea"}, O_BRAM_WEA, 0);
    chk({tag, "_line"}, O_BRAM_LINE, 0);
    chk({tag, "_col"}, O_BRAM_COL, 0);
    chk({tag, "_eng_rd"}, O_ENG_RD_VLD, 0);
    chk({tag, "_host_rd"}, O_HOST_RD_VLD, 0);
    chk({tag, "_err"}, O_ERR, 0);
  endtask
  initial begin
    idle_in();
    I_RST = 1;
    #1;
    I_HOST_REQ = 1; I_ENG_REQ = 1; I_BRAM_RD_VLD = 1;
    #1;
    chk_all_zero("rst");
    cyc();
    chk_all_zero("rst_edge");
    idle_in();
    I_RST = 0;
    cyc();
    // round robin, both reading, first winner ENG
    I_ENG_REQ = 1; I_ENG_LINE = 1; I_ENG_COL = 1;
    I_HOST_REQ = 1; I_HOST_LINE = 2; I_HOST_COL = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_eng_gnt", O_ENG_GNT, (i % 2) == 0);
      chk("rr_host_gnt", O_HOST_GNT, (i % 2) == 1);
      cyc();
      chk("rr_ena", O_BRAM_ENA, 1);
      chk("rr_wea", O_BRAM_WEA, 0);
      chk("rr_line", O_BRAM_LINE, (i % 2) == 0 ? 1 : 2);
      chk("rr_col", O_BRAM_COL, (i % 2) == 0 ? 1 : 2);
    end
    idle_in();
    I_BRAM_RD_VLD = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ret_eng", O_ENG_RD_VLD, (i % 2) == 0);
      chk("rr_ret_host", O_HOST_RD_VLD, (i % 2) == 1);
      cyc();
      chk("rr_ret_idle_ena", O_BRAM_ENA, 0);
    end
    I_BRAM_RD_VLD = 0;
    chk("rr_err", O_ERR, 0);
    // busy: engine strict priority, host request legal
    I_ATTN_BUSY = 1; I_ENG_REQ = 1; I_ENG_WE = 1; I_HOST_REQ = 1; I_HOST_LINE = 7;
    for (int i = 0; i < 4; i++) begin
      I_ENG_LINE = 6'(10 + i); I_ENG_COL = 3'(i);
      #1;
      chk("busy_eng_gnt", O_ENG_GNT, 1);
      chk("busy_host_gnt", O_HOST_GNT, 0);
      cyc();
      chk("busy_ena", O_BRAM_ENA, 1);
      chk("busy_wea", O_BRAM_WEA, 1);
      chk("busy_line", O_BRAM_LINE, 10 + i);
      chk("busy_col", O_BRAM_COL, i);
    end
    chk("busy_err", O_ERR, 0);
    // busy drops: round robin applies in the same cycle, last winner ENG
    I_ATTN_BUSY = 0;
    #1;
    chk("bfall_host_gnt", O_HOST_GNT, 1);
    chk("bfall_eng_gnt", O_ENG_GNT, 0);
    cyc();
    chk("bfall_line", O_BRAM_LINE, 7);
    chk("bfall_wea", O_BRAM_WEA, 0);
    I_HOST_REQ = 0;
    #1;
    chk("bfall_eng_held", O_ENG_GNT, 1);
    cyc();
    idle_in();
    I_BRAM_RD_VLD = 1;
    #1;
    chk("bfall_ret_host", O_HOST_RD_VLD, 1);
    cyc();
    I_BRAM_RD_VLD = 0;
    chk("idle_ena", O_BRAM_ENA, 0);
    chk("idle_line", O_BRAM_LINE, 0);
    // fill the tag FIFO with host reads
    I_HOST_REQ = 1;
    for (int i = 0; i < 4; i++) begin
      I_HOST_LINE = 6'(20 + i);
      #1;
      chk("fill_host_gnt", O_HOST_GNT, 1);
      cyc();
    end
    I_HOST_LINE = 24; I_ENG_REQ = 1; I_ENG_WE = 1; I_ENG_LINE = 30;
    #1;
    chk("full_host_gnt", O_HOST_GNT, 0);
    chk("full_eng_wr_gnt", O_ENG_GNT, 1);
    cyc();
    chk("full_wr_wea", O_BRAM_WEA, 1);
    chk("full_wr_line", O_BRAM_LINE, 30);
    I_ENG_REQ = 0; I_ENG_WE = 0;
    #1;
    chk("full_host_blocked", O_HOST_GNT, 0);
    cyc();
    I_BRAM_RD_VLD = 1;
    #1;
    chk("full_pop_host_gnt", O_HOST_GNT, 1);
    chk("full_pop_host_rd", O_HOST_RD_VLD, 1);
    cyc();
    chk("full_pop_line", O_BRAM_LINE, 24);
    I_HOST_REQ = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_host_rd", O_HOST_RD_VLD, 1);
      chk("drain_eng_rd", O_ENG_RD_VLD, 0);
      cyc();
    end
    I_BRAM_RD_VLD = 0;
    chk("drain_err", O_ERR, 0);
    // ordered return routing ENG, HOST, HOST, ENG
    for (int i = 0; i < 4; i++) begin
      I_ENG_REQ = (i == 0 || i == 3);
      I_HOST_REQ = (i == 1 || i == 2);
      #1;
      chk("ord_gnt", {O_ENG_GNT, O_HOST_GNT}, (i == 0 || i == 3) ? 2'b10 : 2'b01);
      cyc();
    end
    idle_in();
    I_BRAM_RD_VLD = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ord_ret", {O_ENG_RD_VLD, O_HOST_RD_VLD}, (i == 0 || i == 3) ? 2'b10 : 2'b01);
      cyc();
    end
    I_BRAM_RD_VLD = 0;
    chk("ord_err", O_ERR, 0);
    // empty-FIFO return after reset sets a sticky error
    I_RST = 1;
    cyc();
    I_RST = 0;
    cyc();
    I_BRAM_RD_VLD = 1;
    #1;
    chk("err_no_rd", {O_ENG_RD_VLD, O_HOST_RD_VLD}, 0);
    cyc();
    I_BRAM_RD_VLD = 0;
    chk("err_set", O_ERR, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("err_sticky", O_ERR, 1);
    end
    I_RST = 1;
    #1;
    chk("err_cleared", O_ERR, 0);
    cyc();
    I_RST = 0;
    // reset with three reads outstanding
    I_HOST_REQ = 1;
    for (int i = 0; i < 3; i++) begin
      I_HOST_LINE = 6'(40 + i);
      #1;
      chk("out_host_gnt", O_HOST_GNT, 1);
      cyc();
    end
    chk("out_ena", O_BRAM_ENA, 1);
    I_RST = 1;
    #1;
    chk_all_zero("mid_rst");
    cyc();
    I_RST = 0;
    I_HOST_LINE = 5;
    #1;
    chk("post_rst_gnt", O_HOST_GNT, 1);
    cyc();
    chk("post_rst_line", O_BRAM_LINE, 5);
    I_HOST_REQ = 0; I_BRAM_RD_VLD = 1;
    #1;
    chk("post_rst_rd", {O_ENG_RD_VLD, O_HOST_RD_VLD}, 2'b01);
    cyc();
    chk("post_rst_err", O_ERR, 0);
    #1;
    chk("stale_no_rd", {O_ENG_RD_VLD, O_HOST_RD_VLD}, 0);
    cyc();
    I_BRAM_RD_VLD = 0;
    chk("stale_err", O_ERR, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
